pkt_source: RTL
===============

PKT_SOURCE -- requirements
Module: pkt_source

Interface
REQ-001 SHALL have parameter GAP_CYC, default 2, idle cycles inserted between consecutive packets (0 allowed).
REQ-002 SHALL have port sys_clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse launching a burst; sampled only in IDLE.
REQ-005 SHALL have port pkt_len  input  16  packet length in bytes, captured on accepted start.
REQ-006 SHALL have port pkt_cnt  input  16  number of packets in the burst, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high from accepted start until the burst completes.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last beat of the burst is accepted.
REQ-009 SHALL have port err  output  1  sticky; set when start is rejected; cleared by the next accepted start or reset.
REQ-010 SHALL have port out  avln_st source  Line(data DATA_W, sop, eop, empty EMPTY_W) + valid/ready  transmitted stream.

Function
REQ-011 SHALL be an Avalon-ST source with ready latency 0: a beat transfers on a cycle with out.valid && out.ready.
REQ-012 SHALL hold out.line and out.valid stable while out.valid && !out.ready; valid SHALL never drop before transfer.
REQ-013 SHALL implement FSM IDLE -> SEND -> GAP -> SEND ... -> IDLE.
- IDLE: start with pkt_len != 0 and pkt_cnt != 0 -> SEND.
- SEND: last beat transferred -> GAP if more packets remain and GAP_CYC > 0; -> SEND if more remain and GAP_CYC == 0; else -> IDLE with done.
- GAP: after GAP_CYC cycles -> SEND.
REQ-014 SHALL reject start when pkt_len == 0 or pkt_cnt == 0: stay IDLE, set err, no beats.
REQ-015 SHALL ignore start outside IDLE, with no effect on err or the burst in progress.
REQ-016 SHALL assert the first out.valid on the cycle after an accepted start (latency 1).
REQ-017 SHALL send ceil(pkt_len / DATA_BYTES) beats per packet; sop on beat 0, eop on the last beat; both on a single-beat packet.
REQ-018 SHALL drive empty = beats*DATA_BYTES - pkt_len on the eop beat and 0 on all other beats.
REQ-019 SHALL set payload byte k of packet p (0-based) to (p[7:0] + k) mod 256, with byte 0 in data[DATA_W-1 -: 8] (big-endian).
REQ-020 SHALL drive unused bytes of the eop beat as 0.
REQ-021 SHALL wrap the packet index p and the byte value modulo 256 without error.
REQ-022 SHALL drive out.valid = 0 in IDLE and GAP.
REQ-023 SHALL assert busy in SEND and GAP only.
REQ-024 SHALL count pkt_len up to 65535 (8192 beats at DATA_BYTES = 8) without overflow.

Reset
REQ-025 SHALL asynchronously force IDLE, out.valid=0, sop=eop=0, data=0, empty=0, busy=0, done=0, err=0, and clear all counters.
REQ-026 SHALL abandon a packet cut by reset mid-operation; after release the next beat is an sop of a new burst.

Structure
REQ-027 SHALL take Line, avln_st, DATA_W, DATA_BYTES and EMPTY_W from global_types; the FSM state enum SHALL also live in global_types.
REQ-028 SHALL contain one sub-module, pkt_beat_gen: combinational data/empty computation from the packet index, beat index and pkt_len.

Verification
REQ-029 Single packet, DATA_BYTES=8: start, pkt_len=20, pkt_cnt=1, ready=1 -> 3 beats; beat0 sop, data 0x0001020304050607; beat2 eop, empty=4, data 0x1011121300000000; done on the cycle after beat2.
REQ-030 Backpressure: same stimulus, ready low for 3 cycles mid-beat1 -> beat1 held unchanged and valid held high; total 3 transfers.
REQ-031 Burst with gap: pkt_len=8, pkt_cnt=3, GAP_CYC=2 -> 3 sop+eop beats, empty=0, first bytes 0x00, 0x01, 0x02; exactly 2 valid-low cycles between packets.
REQ-032 Reject: start, pkt_len=0 -> err=1, busy=0, no valid; then start, pkt_len=1, pkt_cnt=1 -> err clears, 1 beat with empty=7.
REQ-033 Reset mid-packet: assert reset during beat1 of a 4-beat packet -> valid=0 immediately; after release, a new start yields sop on its first beat.
REQ-034 Wrap: pkt_cnt=257, pkt_len=1 -> packet 256 first byte 0x00; done after packet 256.

Source files
------------

// File: rtl/global_types.sv
// Shared stream types, widths and FSM states for the packet source.
package global_types;

    localparam int DATA_W     = 64;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int EMPTY_W    = $clog2(DATA_BYTES);
    // 8192 beats of 8 bytes cover the full 16-bit packet length
    localparam int BEAT_W     = 13;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } Line;

    typedef struct packed {
        Line  line;
        logic valid;
    } avln_st;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } pkt_state_e;

endpackage

// File: rtl/pkt_beat_gen.sv
// Combinational beat builder: payload bytes, sop/eop and empty for one beat
// of a packet, given the packet index, beat index and packet length.
module pkt_beat_gen
    import global_types::*;
(
    input  logic [7:0]        pkt_idx,
    input  logic [BEAT_W-1:0] beat_idx,
    input  logic [15:0]       pkt_len,
    output Line               line
);

    logic [16:0] base;
    logic [16:0] len_ext;

    assign base    = 17'(beat_idx) << EMPTY_W;
    assign len_ext = {1'b0, pkt_len};

    // Byte k of the packet carries (packet index + k); bytes past the end are zero
    always_comb begin
        line     = '0;
        line.sop = (beat_idx == '0);
        line.eop = (base + 17'(DATA_BYTES)) >= len_ext;
        for (int j = 0; j < DATA_BYTES; j++) begin
            if ((base + 17'(j)) < len_ext) begin
                line.data[DATA_W-1-8*j -: 8] = pkt_idx + 8'(base + 17'(j));
            end
        end
        if (line.eop) begin
            line.empty = EMPTY_W'(0) - pkt_len[EMPTY_W-1:0];
        end
    end

endmodule

// File: rtl/pkt_source.sv
// Avalon-ST packet burst source: on an accepted start it emits pkt_cnt
// packets of pkt_len bytes, with GAP_CYC idle cycles between packets.
module pkt_source
    import global_types::*;
#(
    parameter int GAP_CYC = 2
)
(
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pkt_len,
    input  logic [15:0] pkt_cnt,
    output logic        busy,
    output logic        done,
    output logic        err,
    output avln_st      out,
    input  logic        out_ready
);

    localparam logic [15:0] GAP_LAST = (GAP_CYC > 0) ? 16'(GAP_CYC - 1) : 16'd0;

    pkt_state_e        state;
    logic [15:0]       len_q;
    logic [15:0]       rem_q;
    logic [7:0]        pkt_idx;
    logic [BEAT_W-1:0] beat_idx;
    logic [15:0]       gap_cnt;

    logic [7:0]        gen_pkt;
    logic [BEAT_W-1:0] gen_beat;
    logic [15:0]       gen_len;
    Line               gen_line;
    logic              xfer;

    assign xfer = out.valid && out_ready;

    // Select which beat to prepare next: first beat of a burst, next beat, or next packet
    always_comb begin
        gen_pkt  = pkt_idx;
        gen_beat = '0;
        gen_len  = len_q;
        case (state)
            ST_IDLE: begin
                gen_pkt = '0;
                gen_len = pkt_len;
            end
            ST_SEND: begin
                if (out.line.eop) begin
                    gen_pkt = pkt_idx + 8'd1;
                end else begin
                    gen_beat = beat_idx + BEAT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    pkt_beat_gen u_beat_gen (
        .pkt_idx  (gen_pkt),
        .beat_idx (gen_beat),
        .pkt_len  (gen_len),
        .line     (gen_line)
    );

    // Burst FSM with registered stream and status outputs
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            rem_q    <= '0;
            pkt_idx  <= '0;
            beat_idx <= '0;
            gap_cnt  <= '0;
            out      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (pkt_len == 16'd0 || pkt_cnt == 16'd0) begin
                            err <= 1'b1;
                        end else begin
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            len_q     <= pkt_len;
                            rem_q     <= pkt_cnt;
                            pkt_idx   <= gen_pkt;
                            beat_idx  <= gen_beat;
                            out.line  <= gen_line;
                            out.valid <= 1'b1;
                            state     <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        pkt_idx  <= gen_pkt;
                        beat_idx <= gen_beat;
                        if (!out.line.eop) begin
                            out.line <= gen_line;
                        end else if (rem_q == 16'd1) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            out   <= '0;
                        end else begin
                            rem_q <= rem_q - 16'd1;
                            if (GAP_CYC == 0) begin
                                out.line <= gen_line;
                            end else begin
                                state   <= ST_GAP;
                                gap_cnt <= '0;
                                out     <= '0;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= ST_SEND;
                        out.line  <= gen_line;
                        out.valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
